// File: rtl/prog_ctr_fsm_if.sv
// Fetch sequencer bus: run control and decoder redirects in,
// instruction address, status flags and cycle count out.
interface prog_ctr_fsm_if #(
    parameter int PC_W = 10,
    parameter int CT_W = 16
);
    logic            Start;
    logic            Halt;
    logic            BranchAbs;
    logic            BranchRel;
    logic [PC_W-1:0] Target;
    logic [PC_W-1:0] ProgCtr;
    logic            Running;
    logic            Done;
    logic [CT_W-1:0] CycleCt;

    modport master (
        output Start, Halt, BranchAbs, BranchRel, Target,
        input  ProgCtr, Running, Done, CycleCt
    );

    modport slave (
        input  Start, Halt, BranchAbs, BranchRel, Target,
        output ProgCtr, Running, Done, CycleCt
    );
endinterface

// File: rtl/prog_ctr_fsm.sv
// Program counter and fetch sequencer (IDLE/ARMED/RUN/DONE).
// Ports: Clk, Reset (sync, active-high), bus (slave modport).
module prog_ctr_fsm #(
    parameter int PC_W = 10,
    parameter int CT_W = 16
) (
    input  logic           Clk,
    input  logic           Reset,
    prog_ctr_fsm_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            running;
    logic            done;
    logic [CT_W-1:0] cyc;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            pc      <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            cyc     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    pc <= '0;
                    if (bus.Start) begin
                        state <= ARMED;
                        cyc   <= '0;
                    end
                end
                ARMED: begin
                    pc  <= '0;
                    cyc <= '0;
                    if (!bus.Start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // Count the edge even when it is the one leaving on Halt.
                    if (cyc != {CT_W{1'b1}})
                        cyc <= cyc + CT_W'(1);
                    if (bus.Halt) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (bus.BranchAbs) begin
                        pc <= bus.Target;
                    end else if (bus.BranchRel) begin
                        // Target is a two's-complement offset; carry drops.
                        pc <= pc + bus.Target;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                DONE: begin
                    if (bus.Start) begin
                        state <= ARMED;
                        done  <= 1'b0;
                        pc    <= '0;
                        cyc   <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pc      <= '0;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ProgCtr = pc;
    assign bus.Running = running;
    assign bus.Done    = done;
    assign bus.CycleCt = cyc;
endmodule

// File: doc/prog_ctr_fsm.md
# prog_ctr_fsm

Program counter and fetch sequencer for the single-cycle core. Owns the 10-bit instruction address, holds it across the start handshake, and advances it each cycle by +1, by an absolute jump to the 10-bit target produced by the branch-target lookup table, or by a signed relative offset. It also stops fetching when the program halts and counts executed cycles for benchmarking. Outputs drive instruction-memory address and the top-level Done flag.

## Interface
- PC_W, 10, program counter / target width
- CT_W, 16, cycle counter width
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; overrides all other inputs
- Start  in  1  testbench start level; high = arm/hold, falling level (low while ARMED) = begin run
- Halt  in  1  decoder: current instruction is halt
- BranchAbs  in  1  decoder: take absolute jump to Target
- BranchRel  in  1  decoder: take relative jump PC + Target
- Target  in  PC_W  lookup-table output; unsigned address for BranchAbs, two's-complement offset for BranchRel
- ProgCtr  out  PC_W  current instruction address
- Running  out  1  high in RUN state
- Done  out  1  high in DONE state
- CycleCt  out  CT_W  cycles spent in RUN, saturating

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset -> IDLE.
- IDLE: ProgCtr=0; Start=1 -> ARMED; else stay.
- ARMED: ProgCtr forced to 0, CycleCt cleared to 0; Start=0 -> RUN; else stay.
- RUN: each cycle, next PC by priority: Halt -> PC holds, go DONE; else BranchAbs -> Target; else BranchRel -> PC + Target (PC_W-bit add, carry discarded); else PC + 1 (wraps 10'h3FF -> 10'h000). Start ignored in RUN.
- DONE: ProgCtr holds halt address; Halt/branch inputs ignored; Start=1 -> ARMED (next program).
- Branch inputs outside RUN have no effect.
- CycleCt: +1 on every clock edge taken in RUN (including the edge that leaves on Halt); saturates at 2^CT_W-1; held in IDLE/DONE; cleared only by Reset or entering ARMED.
- Running=1 iff state RUN; Done=1 iff state DONE; both registered state decodes, no input combinational path.

## Timing
- Reset values: ProgCtr=0, Running=0, Done=0, CycleCt=0, state IDLE.
- Reset asserted mid-run: next edge returns to IDLE with all outputs at reset values regardless of Halt/branch/Start.
- ProgCtr is a register; inputs sampled in cycle n determine ProgCtr in cycle n+1 (zero-latency redirect, no bubble).
- First fetched address is 0, in the first RUN cycle (edge after Start seen low in ARMED).
- Done rises one cycle after Halt is sampled high in RUN; Running falls the same edge.
- Simultaneous Halt + branch: halt wins, PC unchanged. Simultaneous BranchAbs + BranchRel: absolute wins.
- Relative with Target=10'h3F0 is -16; PC 10'h005 + 10'h3F0 = 10'h3F5 (wrap, no error).
- Start=1 while in RUN: no effect; program must halt first.

## Test plan
- Reset held 2 cycles with Start=1, Halt=1 -> state IDLE, ProgCtr=0, Running=0, Done=0, CycleCt=0; release -> ARMED next edge.
- Start 1 for 3 cycles then 0, no branches, 5 RUN cycles -> ProgCtr 0,1,2,3,4; Running=1; CycleCt=5.
- In RUN at PC=10'h010, BranchAbs=1 Target=10'h021 -> next ProgCtr=10'h021; then BranchRel Target=10'h3F0 -> 10'h011.
- Force PC to 10'h3FF via BranchAbs Target=10'h3FF, next cycle no branch -> ProgCtr=10'h000; PC 10'h005 + rel 10'h3F0 -> 10'h3F5.
- At PC=10'h0B0, Halt=1 with BranchAbs=1 Target=10'h021 -> ProgCtr stays 10'h0B0, Done=1 next cycle, CycleCt frozen; later Start=1 -> ARMED, ProgCtr=0, CycleCt=0, Done=0.
- Reset pulsed at PC=10'h06C mid-run -> next edge IDLE, ProgCtr=0, CycleCt=0; run CT_W=4 build for 20 RUN cycles -> CycleCt saturates at 15.
